// File: rtl/fmap_reader.sv
// fmap_reader: raster-scan read sequencer for the feature-map BRAM, streaming 2-pixel beats.
// Optional FMAP_RELU_EN: clamp negative pixels to zero as they enter the output FIFO.
module fmap_reader #(
  parameter int W        = 28,
  parameter int H        = 28,
  parameter int ADDR_LEN = 9,
  parameter int BASE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                load,
  output logic [ADDR_LEN:0]   addr1,
  output logic [ADDR_LEN:0]   addr2,
  input  logic signed [7:0]   dout1,
  input  logic signed [7:0]   dout2,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [7:0]   m_data1,
  output logic signed [7:0]   m_data2,
  output logic                m_last
);

  localparam int NBEATS = (W * H) / 2;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW     = ADDR_LEN + 1;

  localparam logic [ADDR_LEN:0] BASE_A    = AW'(BASE);
  localparam logic [ADDR_LEN:0] BASE_B    = AW'(BASE + 1);
  localparam logic [ADDR_LEN:0] ADDR_STEP = AW'(2);
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(NBEATS - 1);

  generate
    if (((W * H) % 2) != 0) begin : g_bad_dims
      $error("fmap_reader: W*H must be even");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  beat_reg;
  logic [ADDR_LEN:0] addr1_reg, addr2_reg;
  logic              inflight_reg, inflight_last_reg;
  logic              start_ok;

  // Skid FIFO entry: {pixel1, pixel2, last}
  logic [16:0]       fifo_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              push, pop;
  logic [2:0]        occ_after_pop;
  logic [16:0]       head;

  function automatic logic signed [7:0] pix(input logic signed [7:0] d);
`ifdef FMAP_RELU_EN
    return (d < 0) ? 8'sd0 : d;
`else
    return d;
`endif
  endfunction

  assign push    = inflight_reg;
  assign m_valid = (count_reg != 2'd0);
  assign pop     = m_valid & m_ready;

  // Occupancy counted after this cycle's pop, so a steady 1 beat/cycle needs only 2 slots.
  assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          start_ok   = 1'b1;
        end
      end
      RUN: begin
        if (occ_after_pop < 3'd2) begin
          load = 1'b1;
          if (beat_reg == LAST_K) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((count_reg == 2'd0) && !inflight_reg) begin
          done       = 1'b1;
          state_next = IDLE;
          if (start) begin
            state_next = RUN;
            start_ok   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      beat_reg          <= '0;
      addr1_reg         <= BASE_A;
      addr2_reg         <= BASE_B;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      inflight_reg      <= load;
      inflight_last_reg <= load && (beat_reg == LAST_K);
      if (start_ok) begin
        beat_reg  <= '0;
        addr1_reg <= BASE_A;
        addr2_reg <= BASE_B;
      end else if (load) begin
        beat_reg  <= beat_reg + 1'b1;
        addr1_reg <= addr1_reg + ADDR_STEP;
        addr2_reg <= addr2_reg + ADDR_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= {pix(dout1), pix(dout2), inflight_last_reg};
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head    = fifo_mem[rd_ptr_reg];
  assign m_data1 = m_valid ? head[16:9] : 8'sd0;
  assign m_data2 = m_valid ? head[8:1]  : 8'sd0;
  assign m_last  = m_valid & head[0];

  assign busy  = (state_reg != IDLE);
  assign addr1 = addr1_reg;
  assign addr2 = addr2_reg;

endmodule
